log_divider: RTL and testbench
==============================

Name: log_divider

Overview:
- Inverse-operation companion to the team's power/product engine.
- Given X and a 4-bit D, computes the quotient/remainder X / D with a restoring shift-subtract divider, and L = floor(log_D(X)) by repeated multiply-compare.
- Both engines run in parallel under one load/start/done FSM; i_select steers the result onto o_P.
- Sits beside the exponent/multiplier block behind the same AXI4-Lite register wrapper.

Parameters:
- XW, 30, width of X, quotient and o_P.
- DW, 4, width of D and remainder.
- LW, 5, width of log result (ceil(log2(XW))).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_load  in  1  latch operands (honoured in IDLE only).
- i_start  in  1  begin calc (in LOAD) / release result (in FINISH).
- i_select  in  1  1 = log result on o_P; 0 = quotient.
- i_X  in  XW  dividend / log argument.
- i_D  in  DW  divisor / log base.
- o_done  out  1  results valid.
- o_P  out  XW  selected result.
- o_R  out  DW  division remainder.
- o_err  out  2  [0] = divide-by-zero (D==0); [1] = log undefined (D<2 or X==0).

Behaviour:
- Reset: asynchronous clear of all state mid-operation. o_done=0, o_P=0, o_R=0, o_err=0, state=IDLE, acc=1, L=0, Q=0, rem=0.
- FSM states: IDLE, LOAD, CALC, FINISH.
- IDLE: holds internals at reset values and drives o_done=0, o_P=0. On i_load, latch X and D, go to LOAD.
- LOAD: on i_start, go to CALC; otherwise wait.
- CALC: i_load and i_start are ignored. Each cycle advances each engine that is not yet done.
- CALC to FINISH: on the edge where div_done and log_done are both already 1.
- FINISH: registers o_done=1. Each cycle o_P <= i_select ? {zero-pad, L} : Q, and o_R <= rem. i_select may toggle live. On i_start, go to IDLE.
- Divider:
  - 30 iterations, MSB first.
  - Per iteration: r = {rem, X[msb-i]} (DW+1 bits). If r >= D then rem <= r-D and Q bit <= 1; else rem <= r and Q bit <= 0.
  - div_done is set on the edge of the 30th iteration.
- Log engine:
  - Product acc*D is XW+DW bits wide.
  - If acc*D <= X: acc <= acc*D and L <= L+1.
  - Otherwise log_done <= 1.
  - L <= 29 always.
- Errors:
  - D==0: no divide iterations; Q = all ones, rem = 0, o_err[0] = 1, div_done set on the first CALC edge.
  - D<2 or X==0: L = 0, o_err[1] = 1, log_done set on the first CALC edge.
  - o_err is registered in FINISH and cleared in IDLE.
- Latency:
  - LOAD->CALC edge = E0.
  - Normal case: FINISH entered at E31, o_done high after E32 (fixed 32 cycles).
  - Both engines in error: o_done high after E3.

Optional Feature:
- LOGDIV_CYCLE_CNT_EN: when defined, adds port o_cycles (out, 6 bits).
  - Counts CALC-state cycles: cleared in IDLE, incremented each CALC cycle, frozen in FINISH. Normal run = 31.
- When undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Package logdiv_pkg:
  - State encoding (IDLE=0, LOAD=1, CALC=2, FINISH=3).
  - XW/DW/LW defaults.
  - Error bit indices.
  - DIV_ITERS=30.
- One sub-module is natural: restoring_div_step, a combinational single iteration (rem, next bit, D -> rem', qbit).

Test Plan:
- X=100, D=7, select=0 -> o_P=14, o_R=2, o_err=0; o_done exactly 32 cycles after start accepted. Then select=1 -> o_P=2.
- X=81, D=3, select=1 -> o_P=4; select=0 -> o_P=27, o_R=0.
- X=0x3FFFFFFF, D=2 -> log o_P=29, quotient 0x1FFFFFFF, o_R=1.
- D=0, X=5 -> o_err=2'b11, quotient all ones, log 0. D=1, X=9 -> o_err=2'b10, quotient 9, o_R=0.
- Reset asserted mid-CALC, then X=50, D=5 reloaded -> o_done=0 immediately; fresh run gives Q=10, L=2. i_load pulsed during CALC is ignored.
- FINISH with i_start -> IDLE: o_done=0 and o_P=0 next cycle. With LOGDIV_CYCLE_CNT_EN, o_cycles=31 on a normal run.

Source files
------------

// File: rtl/logdiv_pkg.sv
// Shared types and constants for the log/divide engine.
package logdiv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CALC   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int XW_DEF    = 30;
  localparam int DW_DEF    = 4;
  localparam int LW_DEF    = 5;
  localparam int ERR_DIV0  = 0;
  localparam int ERR_LOG   = 1;
  localparam int DIV_ITERS = 30;

endpackage

// File: rtl/log_divider_restoring_div_step.sv
// One combinational iteration of a restoring shift-subtract divider.
module restoring_div_step #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] rem,
  input  logic          din,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] rem_next,
  output logic          qbit
);

  logic [DW:0] r;
  logic [DW:0] diff;

  always_comb begin
    r        = {rem, din};
    diff     = r - {1'b0, d};
    qbit     = (r >= {1'b0, d});
    // A successful subtract leaves diff < d, so it always fits in DW bits
    rem_next = qbit ? diff[DW-1:0] : r[DW-1:0];
  end

endmodule

// File: rtl/log_divider.sv
// Quotient/remainder X/D and floor(log_D(X)) computed in parallel under one FSM.
// Optional macro LOGDIV_CYCLE_CNT_EN adds the o_cycles CALC-cycle counter port.
module log_divider
  import logdiv_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int DW = DW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_start,
  input  logic          i_select,
  input  logic [XW-1:0] i_X,
  input  logic [DW-1:0] i_D,
  output logic          o_done,
  output logic [XW-1:0] o_P,
  output logic [DW-1:0] o_R,
  output logic [1:0]    o_err
`ifdef LOGDIV_CYCLE_CNT_EN
  ,
  output logic [5:0]    o_cycles
`endif
);

  localparam int IW = $clog2(DIV_ITERS);

  state_t state_q, state_d;

  logic [XW-1:0]    x_q, x_sh, q, acc;
  logic [DW-1:0]    d_q, rem, rem_next;
  logic [LW-1:0]    l;
  logic [IW-1:0]    idx;
  logic             div_done, log_done, qbit;
  logic             div_err, log_err;
  logic [XW+DW-1:0] prod;

  assign div_err = (d_q == '0);
  assign log_err = (d_q < DW'(2)) || (x_q == '0);
  assign prod    = {{DW{1'b0}}, acc} * {{XW{1'b0}}, d_q};

  restoring_div_step #(.DW(DW)) u_step (
    .rem      (rem),
    .din      (x_sh[XW-1]),
    .d        (d_q),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_load) state_d = LOAD;
      LOAD:    if (i_start) state_d = CALC;
      CALC:    if (div_done && log_done) state_d = FINISH;
      FINISH:  if (i_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and both engines
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q      <= '0;
      d_q      <= '0;
      x_sh     <= '0;
      q        <= '0;
      rem      <= '0;
      idx      <= '0;
      div_done <= 1'b0;
      acc      <= XW'(1);
      l        <= '0;
      log_done <= 1'b0;
    end else if (state_q == IDLE) begin
      q        <= '0;
      rem      <= '0;
      idx      <= '0;
      div_done <= 1'b0;
      acc      <= XW'(1);
      l        <= '0;
      log_done <= 1'b0;
      if (i_load) begin
        x_q  <= i_X;
        d_q  <= i_D;
        x_sh <= i_X;
      end
    end else if (state_q == CALC) begin
      if (!div_done) begin
        if (div_err) begin
          q        <= '1;
          rem      <= '0;
          div_done <= 1'b1;
        end else begin
          rem  <= rem_next;
          q    <= {q[XW-2:0], qbit};
          x_sh <= {x_sh[XW-2:0], 1'b0};
          idx  <= idx + IW'(1);
          if (idx == IW'(DIV_ITERS - 1)) div_done <= 1'b1;
        end
      end
      if (!log_done) begin
        if (log_err) begin
          l        <= '0;
          log_done <= 1'b1;
        end else if (prod <= {{DW{1'b0}}, x_q} && l != LW'(XW - 1)) begin
          acc <= prod[XW-1:0];
          l   <= l + LW'(1);
        end else begin
          log_done <= 1'b1;
        end
      end
    end
  end

  // Registered result outputs, cleared as soon as the result is released
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_done <= 1'b0;
      o_P    <= '0;
      o_R    <= '0;
      o_err  <= '0;
    end else if (state_q == IDLE || (state_q == FINISH && i_start)) begin
      o_done <= 1'b0;
      o_P    <= '0;
      o_R    <= '0;
      o_err  <= '0;
    end else if (state_q == FINISH) begin
      o_done          <= 1'b1;
      o_P             <= i_select ? {{(XW-LW){1'b0}}, l} : q;
      o_R             <= rem;
      o_err[ERR_DIV0] <= div_err;
      o_err[ERR_LOG]  <= log_err;
    end
  end

`ifdef LOGDIV_CYCLE_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               o_cycles <= '0;
    else if (state_q == IDLE)   o_cycles <= '0;
    else if (state_q == CALC)   o_cycles <= o_cycles + 6'd1;
  end
`endif

endmodule

// File: tb/tb_log_divider.sv
// Table-driven bench for log_divider: quotient, remainder, log, errors, latency.
module tb_log_divider;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_load, i_start, i_select;
  logic [29:0] i_X;
  logic [3:0]  i_D;
  logic        o_done;
  logic [29:0] o_P;
  logic [3:0]  o_R;
  logic [1:0]  o_err;
`ifdef LOGDIV_CYCLE_CNT_EN
  logic [5:0]  o_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  log_divider dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (i_load),
    .i_start  (i_start),
    .i_select (i_select),
    .i_X      (i_X),
    .i_D      (i_D),
    .o_done   (o_done),
    .o_P      (o_P),
    .o_R      (o_R),
    .o_err    (o_err)
`ifdef LOGDIV_CYCLE_CNT_EN
    ,
    .o_cycles (o_cycles)
`endif
  );

  typedef struct {
    logic [29:0] x;
    logic [3:0]  d;
    logic [29:0] q;
    logic [3:0]  r;
    logic [29:0] l;
    logic [1:0]  err;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load, start, then count cycles after E0 until o_done rises
  task automatic start_and_wait(input vec_t v, input bit poke_load, output int cnt);
    @(negedge i_clk);
    i_X = v.x; i_D = v.d; i_load = 1'b1;
    @(negedge i_clk);
    i_load = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    cnt = 0;
    while (1) begin
      @(posedge i_clk);
      #1;
      cnt++;
      if (poke_load && cnt == 4) begin
        i_X = 30'd1000; i_D = 4'd3; i_load = 1'b1; i_start = 1'b1;
      end
      if (poke_load && cnt == 5) begin
        i_load = 1'b0; i_start = 1'b0;
      end
      if (o_done) break;
      if (cnt > 200) begin
        errors++;
        $display("FAIL timeout: o_done not seen after %0d cycles", cnt);
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input bit poke_load);
    int cnt;
    i_select = 1'b0;
    start_and_wait(v, poke_load, cnt);
    check("latency", cnt, v.lat);
    check("quotient", o_P, v.q);
    check("remainder", o_R, v.r);
    check("err", o_err, v.err);
`ifdef LOGDIV_CYCLE_CNT_EN
    check("cycles", o_cycles, v.lat - 1);
`endif
    @(negedge i_clk);
    i_select = 1'b1;
    @(posedge i_clk); #1;
    check("log", o_P, v.l);
    @(negedge i_clk);
    i_select = 1'b0;
    @(posedge i_clk); #1;
    check("quotient_again", o_P, v.q);
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    check("release_done", o_done, 1'b0);
    check("release_P", o_P, 30'd0);
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0] = '{30'd100,        4'd7, 30'd14,         4'd2, 30'd2,  2'b00, 32};
    vecs[1] = '{30'd81,         4'd3, 30'd27,         4'd0, 30'd4,  2'b00, 32};
    vecs[2] = '{30'h3FFFFFFF,   4'd2, 30'h1FFFFFFF,   4'd1, 30'd29, 2'b00, 32};
    vecs[3] = '{30'd5,          4'd0, 30'h3FFFFFFF,   4'd0, 30'd0,  2'b11, 3};
    vecs[4] = '{30'd9,          4'd1, 30'd9,          4'd0, 30'd0,  2'b10, 32};
    vecs[5] = '{30'd1,          4'd15, 30'd0,         4'd1, 30'd0,  2'b00, 32};
    vecs[6] = '{30'd0,          4'd5, 30'd0,          4'd0, 30'd0,  2'b10, 32};
    vecs[7] = '{30'd50,         4'd5, 30'd10,         4'd0, 30'd2,  2'b00, 32};

    i_rst_n = 1'b0; i_load = 1'b0; i_start = 1'b0; i_select = 1'b0;
    i_X = '0; i_D = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_done", o_done, 1'b0);
    check("reset_P", o_P, 30'd0);
    check("reset_R", o_R, 4'd0);
    check("reset_err", o_err, 2'b00);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

    // Reset in the middle of CALC, then a fresh run with i_load poked during CALC
    @(negedge i_clk);
    i_X = 30'd100; i_D = 4'd7; i_load = 1'b1;
    @(negedge i_clk);
    i_load = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midcalc_rst_done", o_done, 1'b0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_vec(vecs[7], 1'b1);

    // Reset while results are being presented clears them at once
    i_select = 1'b0;
    start_and_wait(vecs[0], 1'b0, cnt);
    check("pre_rst_done", o_done, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("finish_rst_done", o_done, 1'b0);
    check("finish_rst_P", o_P, 30'd0);
    check("finish_rst_R", o_R, 4'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_vec(vecs[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
